// File: rtl/emitter_stream.sv
// emitter_stream: streams one output-buffer window per go request to the left/right codec sinks; optional go queue under EMITTER_GO_QUEUE_EN
module emitter_stream #(
  parameter int DATA_W = 16,
  parameter int WINDOW_LEN = 512,
  parameter int NUM_WINDOWS = 4,
  localparam int WIN_W = NUM_WINDOWS > 1 ? $clog2(NUM_WINDOWS) : 1,
  localparam int ADDR_W = NUM_WINDOWS * WINDOW_LEN > 1 ? $clog2(NUM_WINDOWS * WINDOW_LEN) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WIN_W-1:0]  window_start,
  input  logic              go_in,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] buf_rd_addr,
  output logic              buf_rd_en,
  input  logic [DATA_W-1:0] buf_rd_data,
  output logic [DATA_W-1:0] left_out_data,
  output logic              left_out_valid,
  input  logic              left_out_ready,
  output logic [DATA_W-1:0] right_out_data,
  output logic              right_out_valid,
  input  logic              right_out_ready
);
  localparam int IDX_W = WINDOW_LEN > 1 ? $clog2(WINDOW_LEN) : 1;
  typedef enum logic [2:0] {IDLE, FETCH, WAIT, PRESENT, DONE} state_t;
  state_t state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic lv_q, lv_d, rv_q, rv_d;
  logic go_ok;
  assign go_ok = go_in && (32'(window_start) < NUM_WINDOWS);
  assign busy = state_q != IDLE;
  assign done = state_q == DONE;
  assign buf_rd_en = state_q == FETCH;
  assign buf_rd_addr = base_q + ADDR_W'(idx_q);
  assign left_out_data = data_q;
  assign right_out_data = data_q;
  assign left_out_valid = lv_q;
  assign right_out_valid = rv_q;
`ifdef EMITTER_GO_QUEUE_EN
  logic pend_q, pend_d;
  logic [WIN_W-1:0] pend_win_q, pend_win_d;
  // a go arriving while busy is parked; the newest request overwrites older ones
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      pend_q <= 1'b0;
      pend_win_q <= '0;
    end else begin
      pend_q <= pend_d;
      pend_win_q <= pend_win_d;
    end
`endif
  // sequencer state, sample index, window base and per-channel valid flags
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      idx_q <= '0;
      base_q <= '0;
      data_q <= '0;
      lv_q <= 1'b0;
      rv_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      base_q <= base_d;
      data_q <= data_d;
      lv_q <= lv_d;
      rv_q <= rv_d;
    end
  // next-state: fetch one sample, present it to both sinks, advance once both have taken it
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    base_d = base_q;
    data_d = data_q;
    lv_d = lv_q;
    rv_d = rv_q;
`ifdef EMITTER_GO_QUEUE_EN
    pend_d = pend_q;
    pend_win_d = pend_win_q;
    if (state_q != IDLE && go_ok) begin
      pend_d = 1'b1;
      pend_win_d = window_start;
    end
`endif
    case (state_q)
      IDLE:
        if (go_ok) begin
          base_d = ADDR_W'(window_start) * ADDR_W'(WINDOW_LEN);
          idx_d = '0;
          state_d = FETCH;
        end
      FETCH: state_d = WAIT;
      WAIT: begin
        data_d = buf_rd_data;
        lv_d = 1'b1;
        rv_d = 1'b1;
        state_d = PRESENT;
      end
      PRESENT: begin
        lv_d = lv_q && !left_out_ready;
        rv_d = rv_q && !right_out_ready;
        if (!lv_d && !rv_d) begin
          state_d = idx_q == IDX_W'(WINDOW_LEN - 1) ? DONE : FETCH;
          idx_d = idx_q == IDX_W'(WINDOW_LEN - 1) ? idx_q : idx_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
`ifdef EMITTER_GO_QUEUE_EN
        if (go_ok || pend_q) begin
          base_d = ADDR_W'(go_ok ? window_start : pend_win_q) * ADDR_W'(WINDOW_LEN);
          idx_d = '0;
          state_d = FETCH;
          pend_d = 1'b0;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_emitter_stream.sv
// tb_emitter_stream: randomized-ready stream checks of emitter_stream against a window/sample queue model
module tb_emitter_stream;
  localparam int WL = 8;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [1:0] window_start = '0;
  logic go_in = 1'b0;
  logic busy, done, buf_rd_en;
  logic [4:0] buf_rd_addr;
  logic [15:0] buf_rd_data, left_out_data, right_out_data;
  logic left_out_valid, right_out_valid;
  logic left_out_ready = 1'b0, right_out_ready = 1'b0;
  logic [1:0] ws3 = '0;
  logic go3 = 1'b0;
  logic busy3, done3, en3, lv3, rv3;
  logic [4:0] addr3;
  logic [15:0] rd3, l3, r3;
  int checks = 0, errors = 0, done_cnt = 0, exp_done = 0, lhead = 0, rhead = 0;
  logic [15:0] exp_q[$];
  logic pl_v = 1'b0, pr_v = 1'b0, pl_x = 1'b0, pr_x = 1'b0;
  logic [15:0] pl_d = '0, pr_d = '0;
  always #5 clk = ~clk;
  emitter_stream #(.DATA_W(16), .WINDOW_LEN(WL), .NUM_WINDOWS(4)) dut (
    .clk(clk), .reset(reset), .window_start(window_start), .go_in(go_in),
    .busy(busy), .done(done), .buf_rd_addr(buf_rd_addr), .buf_rd_en(buf_rd_en),
    .buf_rd_data(buf_rd_data), .left_out_data(left_out_data), .left_out_valid(left_out_valid),
    .left_out_ready(left_out_ready), .right_out_data(right_out_data),
    .right_out_valid(right_out_valid), .right_out_ready(right_out_ready));
  emitter_stream #(.DATA_W(16), .WINDOW_LEN(WL), .NUM_WINDOWS(3)) dut3 (
    .clk(clk), .reset(reset), .window_start(ws3), .go_in(go3),
    .busy(busy3), .done(done3), .buf_rd_addr(addr3), .buf_rd_en(en3),
    .buf_rd_data(rd3), .left_out_data(l3), .left_out_valid(lv3),
    .left_out_ready(1'b1), .right_out_data(r3),
    .right_out_valid(rv3), .right_out_ready(1'b1));
  always @(posedge clk) if (buf_rd_en) buf_rd_data <= 16'(buf_rd_addr);
  always @(posedge clk) if (en3) rd3 <= 16'(addr3);
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  // sink-side monitor: every accepted sample must be the next one the model expects, held stable until taken
  always @(negedge clk) begin
    if (reset) begin
      lhead = exp_q.size();
      rhead = lhead;
      pl_v = 1'b0;
      pr_v = 1'b0;
    end else begin
      if (pl_v && !pl_x) begin
        check("l_hold_v", left_out_valid, 1);
        check("l_hold_d", left_out_data, pl_d);
      end
      if (pr_v && !pr_x) begin
        check("r_hold_v", right_out_valid, 1);
        check("r_hold_d", right_out_data, pr_d);
      end
      if (left_out_valid && left_out_ready) begin
        if (lhead < exp_q.size()) begin
          check("l_data", left_out_data, exp_q[lhead]);
          lhead++;
        end else check("l_extra", left_out_valid, 0);
      end
      if (right_out_valid && right_out_ready) begin
        if (rhead < exp_q.size()) begin
          check("r_data", right_out_data, exp_q[rhead]);
          rhead++;
        end else check("r_extra", right_out_valid, 0);
      end
      if (buf_rd_en) check("rd_while_valid", left_out_valid | right_out_valid, 0);
      if (done) begin
        done_cnt++;
        check("done_l_window", lhead % WL, 0);
        check("done_lr", lhead, rhead);
      end
      pl_v = left_out_valid;
      pl_x = left_out_valid && left_out_ready;
      pl_d = left_out_data;
      pr_v = right_out_valid;
      pr_x = right_out_valid && right_out_ready;
      pr_d = right_out_data;
    end
  end
  task automatic start(input int w, input bit push);
    @(posedge clk);
    #1 window_start = 2'(w);
    go_in = 1'b1;
    @(posedge clk);
    #1 go_in = 1'b0;
    if (push) begin
      for (int i = 0; i < WL; i++) exp_q.push_back(16'(w * WL + i));
      exp_done++;
      check("busy_go", busy, 1);
    end
  endtask
  task automatic wait_done(input int budget, output int idle);
    idle = 0;
    for (int i = 0; i < budget && done_cnt < exp_done; i++) begin
      @(negedge clk);
      #1 if (!busy) idle++;
    end
    check("done_cnt", done_cnt, exp_done);
  endtask
  initial begin
    int idle;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_en", buf_rd_en, 0);
    check("rst_addr", buf_rd_addr, 0);
    check("rst_valid", {left_out_valid, right_out_valid}, 0);
    check("rst_data", {left_out_data, right_out_data}, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    left_out_ready = 1'b1;
    right_out_ready = 1'b1;
    start(2, 1);
    wait_done(200, idle);
    @(negedge clk);
    check("busy_after_done", busy, 0);
    check("done_single", done, 0);
    start(2, 1);
    for (int i = 0; i < 100 && !(buf_rd_en && buf_rd_addr == 5'd19); i++) @(negedge clk);
    check("saw_rd19", buf_rd_addr, 19);
    right_out_ready = 1'b0;
    repeat (5) @(posedge clk);
    #1 check("r_stall_valid", right_out_valid, 1);
    check("r_stall_data", right_out_data, 19);
    check("l_stall_valid", left_out_valid, 0);
    right_out_ready = 1'b1;
    wait_done(200, idle);
    start(0, 1);
    for (int i = 0; i < 800 && done_cnt < exp_done; i++) begin
      @(posedge clk);
      #1 left_out_ready = 1'($urandom_range(0, 1));
      right_out_ready = 1'($urandom_range(0, 1));
    end
    check("rand_done", done_cnt, exp_done);
    left_out_ready = 1'b1;
    right_out_ready = 1'b1;
    start(1, 1);
    exp_done--;
    for (int i = 0; i < 100 && !(buf_rd_en && buf_rd_addr == 5'd12); i++) @(negedge clk);
    check("saw_rd12", buf_rd_addr, 12);
    left_out_ready = 1'b0;
    right_out_ready = 1'b0;
    for (int i = 0; i < 10 && !left_out_valid; i++) @(negedge clk);
    #1 reset = 1'b1;
    #1 check("arst_valid", {left_out_valid, right_out_valid}, 0);
    check("arst_busy", busy, 0);
    check("arst_en", buf_rd_en, 0);
    check("arst_data", left_out_data, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    left_out_ready = 1'b1;
    right_out_ready = 1'b1;
    repeat (10) @(posedge clk);
    check("arst_no_done", done_cnt, exp_done);
    start(3, 1);
    wait_done(200, idle);
    start(2, 1);
    repeat (4) @(posedge clk);
    #1 window_start = 2'd1;
    go_in = 1'b1;
    @(posedge clk);
    #1 go_in = 1'b0;
`ifdef EMITTER_GO_QUEUE_EN
    for (int i = 0; i < WL; i++) exp_q.push_back(16'(WL + i));
    exp_done++;
`endif
    wait_done(400, idle);
    check("busy_gap", idle, 0);
    repeat (40) @(posedge clk);
    check("done_total", done_cnt, exp_done);
    check("l_drain", lhead, exp_q.size());
    check("r_drain", rhead, exp_q.size());
    @(posedge clk);
    #1 ws3 = 2'd3;
    go3 = 1'b1;
    @(posedge clk);
    #1 go3 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("nw3_busy", busy3, 0);
      check("nw3_en", en3, 0);
    end
    @(posedge clk);
    #1 ws3 = 2'd2;
    go3 = 1'b1;
    @(posedge clk);
    #1 go3 = 1'b0;
    @(negedge clk);
    check("nw3_ok_busy", busy3, 1);
    check("nw3_ok_addr", addr3, 16);
    for (int i = 0; i < 100 && !done3; i++) @(negedge clk);
    check("nw3_done", done3, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
